counter_prescaler: RTL

Parametrised free-running modulo counter that generalises the fixed-width display prescaler. It adds a programmable terminal value, count enable, up/down direction, synchronous load and a one-cycle wrap tick. It sits between the board clock and the slow-rate consumers: display digit multiplexing uses `msbs`, and timers and debouncers use `tick`.

---
 rtl/counter_prescaler.sv | 83 ++++++++
 1 files changed

// File: rtl/counter_prescaler.sv
// Programmable modulo up/down counter with load and wrap tick.
// Define COUNTER_PRESCALER_TICK_EN to build the tick register.
module counter_prescaler #(
  parameter int unsigned N = 23,
  parameter int unsigned M = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max,
  output logic [N-1:0] count,
  output logic [M-1:0] msbs,
  output logic         tick
);

  logic [N-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (!dir) begin
        if (count_q >= max) begin
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        // An out-of-range count snaps to max without wrapping.
        if (count_q == '0) begin
          count_d = max;
        end else if (count_q > max) begin
          count_d = max;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign msbs  = count_q[N-1 -: M];

`ifdef COUNTER_PRESCALER_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = 1'b0;
    if (!load && en) begin
      if (!dir) begin
        tick_d = (count_q >= max);
      end else begin
        tick_d = (count_q == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule
